// File: rtl/lt_pkg.sv
// Shared constants, FSM state type and CDF threshold table for the
// LT degree mapper (truncated robust soliton, 8 bins, 14-bit samples).
package lt_pkg;

  localparam int unsigned RAND_W  = 14;
  localparam int unsigned NUM_DEG = 8;
  localparam int unsigned DEG_W   = 4;
  localparam int unsigned IDX_W   = $clog2(NUM_DEG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Cumulative thresholds; the last entry is all-ones so every sample maps.
  localparam logic [RAND_W-1:0] THR [NUM_DEG] = '{
    14'd1638,  14'd9830,  14'd12015, 14'd13107,
    14'd13763, 14'd14199, 14'd14512, 14'd16383
  };

  function automatic logic [RAND_W-1:0] thr_lookup(input logic [IDX_W-1:0] idx);
    return THR[idx];
  endfunction

endpackage

// File: rtl/lt_thr_rom.sv
// Combinational index -> threshold lookup.
// LT_DEGREE_MAP_FAST_SCAN_EN adds a second read port for the dual-compare scan.
module lt_thr_rom
  import lt_pkg::*;
(
  input  logic [IDX_W-1:0]  idx_a,
  output logic [RAND_W-1:0] thr_a
`ifdef LT_DEGREE_MAP_FAST_SCAN_EN
  ,
  input  logic [IDX_W-1:0]  idx_b,
  output logic [RAND_W-1:0] thr_b
`endif
);

  // Primary read port.
  always_comb begin
    thr_a = thr_lookup(idx_a);
  end

`ifdef LT_DEGREE_MAP_FAST_SCAN_EN
  // Secondary read port for the idx+1 entry.
  always_comb begin
    thr_b = thr_lookup(idx_b);
  end
`endif

endmodule

// File: rtl/lt_degree_map.sv
// Maps a uniform random sample to an LT encoding degree by a sequential
// scan of the CDF threshold table, with a valid/ready result handshake.
// Optional macro LT_DEGREE_MAP_FAST_SCAN_EN: two table compares per cycle.
module lt_degree_map
  import lt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RAND_W-1:0] rand_in,
  input  logic              req,
  output logic              busy,
  output logic              deg_valid,
  input  logic              deg_ready,
  output logic [DEG_W-1:0]  degree
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DEG - 1);

  state_t            state_q, state_d;
  logic [RAND_W-1:0] sample_q, sample_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DEG_W-1:0]  degree_q, degree_d;
  logic [RAND_W-1:0] thr_a;

`ifdef LT_DEGREE_MAP_FAST_SCAN_EN
  logic [IDX_W-1:0]  idx_b;
  logic [RAND_W-1:0] thr_b;

  // Second compare looks one entry ahead, clamped at the last bin.
  always_comb begin
    idx_b = (idx_q == LAST_IDX) ? idx_q : idx_q + IDX_W'(1);
  end

  lt_thr_rom u_rom (
    .idx_a (idx_q),
    .thr_a (thr_a),
    .idx_b (idx_b),
    .thr_b (thr_b)
  );
`else
  lt_thr_rom u_rom (
    .idx_a (idx_q),
    .thr_a (thr_a)
  );
`endif

  // State, sample, scan index and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      idx_q    <= '0;
      degree_q <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      degree_q <= degree_d;
    end
  end

  // Next-state logic: accept, scan the table, hold the result until taken.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    degree_d = degree_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          sample_d = rand_in;
          idx_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
`ifdef LT_DEGREE_MAP_FAST_SCAN_EN
        if (sample_q <= thr_a) begin
          degree_d = DEG_W'(idx_q) + DEG_W'(1);
          state_d  = HOLD;
        end else if (sample_q <= thr_b) begin
          degree_d = DEG_W'(idx_q) + DEG_W'(2);
          state_d  = HOLD;
        end else if (idx_b == LAST_IDX) begin
          degree_d = DEG_W'(NUM_DEG);
          state_d  = HOLD;
        end else begin
          idx_d = idx_q + IDX_W'(2);
        end
`else
        if (sample_q <= thr_a) begin
          degree_d = DEG_W'(idx_q) + DEG_W'(1);
          state_d  = HOLD;
        end else if (idx_q == LAST_IDX) begin
          degree_d = DEG_W'(NUM_DEG);
          state_d  = HOLD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
`endif
      end
      HOLD: begin
        if (deg_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status and result outputs decoded from state.
  always_comb begin
    busy      = (state_q != IDLE);
    deg_valid = (state_q == HOLD);
    degree    = degree_q;
  end

endmodule

// File: tb/tb_lt_degree_map.sv
// Self-checking bench for lt_degree_map: directed boundary cases, backpressure,
// same-cycle handshake/req, async reset mid-scan and random samples.
module tb_lt_degree_map;

  logic        clk;
  logic        rst;
  logic [13:0] rand_in;
  logic        req;
  logic        busy;
  logic        deg_valid;
  logic        deg_ready;
  logic [3:0]  degree;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned thr_ref [8] = '{1638, 9830, 12015, 13107, 13763, 14199, 14512, 16383};

  lt_degree_map dut (
    .clk       (clk),
    .rst       (rst),
    .rand_in   (rand_in),
    .req       (req),
    .busy      (busy),
    .deg_valid (deg_valid),
    .deg_ready (deg_ready),
    .degree    (degree)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned ref_degree(input int unsigned s);
    for (int d = 1; d <= 8; d++) begin
      if (s <= thr_ref[d-1]) return d;
    end
    return 8;
  endfunction

  // Cycles from the accepting cycle to the first deg_valid cycle.
  function automatic int unsigned ref_latency(input int unsigned d);
`ifdef LT_DEGREE_MAP_FAST_SCAN_EN
    return (d + 1) / 2 + 1;
`else
    return d + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one req (caller is in an IDLE cycle), wait for the result,
  // check latency and degree, leave the DUT in HOLD.
  task automatic request_and_wait(input int unsigned s, input string tag);
    int unsigned d, n;
    d = ref_degree(s);
    rand_in = 14'(s);
    req = 1'b1;
    step();
    req = 1'b0;
    n = 1;
    while (!deg_valid && n < 40) begin
      rand_in = 14'($urandom);
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(deg_valid), 32'd1);
    check({tag, "_latency"}, n, ref_latency(d));
    check({tag, "_degree"}, 32'(degree), d);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic complete();
    deg_ready = 1'b1;
    step();
    deg_ready = 1'b0;
    check("done_valid", 32'(deg_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_one(input int unsigned s, input string tag);
    request_and_wait(s, tag);
    complete();
  endtask

  initial begin
    int unsigned seen_valid;
    rst = 1'b1;
    req = 1'b0;
    deg_ready = 1'b0;
    rand_in = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(deg_valid), 32'd0);
    check("rst_degree", 32'(degree), 32'd0);
    rst = 1'b0;
    step();

    // Directed boundaries from the threshold table.
    run_one(0, "s0");
    run_one(1638, "s1638");
    run_one(1639, "s1639");
    run_one(16383, "s16383");
    run_one(14513, "s14513");
    run_one(14512, "s14512");
    for (int i = 0; i < 8; i++) begin
      run_one(thr_ref[i], "thr_eq");
      if (i < 7) run_one(thr_ref[i] + 1, "thr_plus1");
    end

    // Backpressure: result held, busy held, req during hold ignored.
    request_and_wait(12000, "bp");
    for (int i = 0; i < 5; i++) begin
      req = 1'b1;
      rand_in = '0;
      step();
      check("bp_hold_valid", 32'(deg_valid), 32'd1);
      check("bp_hold_degree", 32'(degree), 32'd3);
      check("bp_hold_busy", 32'(busy), 32'd1);
    end
    req = 1'b0;
    complete();
    step();
    check("bp_not_queued", 32'(busy), 32'd0);

    // Handshake completion with req in the same cycle.
    request_and_wait(5000, "hs");
    deg_ready = 1'b1;
    req = 1'b1;
    rand_in = 14'd13000;
    step();
    deg_ready = 1'b0;
    check("hs_no_accept", 32'(busy), 32'd0);
    request_and_wait(13000, "hs_next");
    complete();

    // Async reset mid-scan discards the pending result.
    rand_in = 14'd16383;
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(deg_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (deg_valid || busy) seen_valid++;
    end
    check("post_rst_quiet", seen_valid, 0);
    run_one(1639, "post_rst");

    // Random samples against the reference mapping.
    for (int i = 0; i < 300; i++) begin
      run_one($urandom_range(16383, 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lt_degree_map.md
Name: lt_degree_map

Overview:
- Downstream consumer of the 14-bit LFSR random word in the LT/fountain encoder path.
- Maps one uniform 14-bit sample onto an encoding degree 1..NUM_DEG using a cumulative-distribution threshold table (truncated robust soliton).
- Scans the table sequentially and hands the degree to the packet-combiner stage over a valid/ready handshake.

Parameters:
- RAND_W, 14, width of the random sample; must match the LFSR output.
- NUM_DEG, 8, number of degree bins; degrees 1..NUM_DEG.
- DEG_W, 4, degree output width; must satisfy NUM_DEG < 2**DEG_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rand_in  in  RAND_W  random sample from the LFSR; sampled only on an accepted req.
- req  in  1  request one degree; accepted only when busy=0.
- busy  out  1  high from the cycle after acceptance until the degree handshake completes.
- deg_valid  out  1  degree output valid.
- deg_ready  in  1  downstream ready.
- degree  out  DEG_W  mapped degree; meaningful only while deg_valid=1.

Behaviour:
- Reset values: busy=0, deg_valid=0, degree=0; FSM in IDLE; sample register and index cleared.
- FSM states:
  - IDLE: on req=1, latch rand_in, set idx=0, go to SCAN.
  - SCAN: each cycle compare the sample against THR[idx].
    - sample <= THR[idx]: latch degree=idx+1 and go to HOLD.
    - otherwise: idx++ and stay in SCAN.
  - HOLD: deg_valid=1 and degree held stable; on deg_ready=1, go to IDLE.
- Mapping rule: degree = smallest d with sample <= THR[d-1]. Comparison is unsigned, RAND_W bits.
- THR[NUM_DEG-1] = 2**RAND_W-1, so the scan always terminates. idx never exceeds NUM_DEG-1. If it reaches the last entry, the result is forced to NUM_DEG.
- Latency: req accepted in cycle T gives deg_valid=1 in cycle T+d+1 for degree d. Degree 1 → T+2; degree 8 → T+9.
- busy=1 in SCAN and HOLD. busy is combinational from state.
- req while busy is ignored, not queued. rand_in changes after acceptance have no effect.
- deg_valid and degree are held unchanged through backpressure (deg_ready=0), for any number of cycles.
- Handshake completion and req in the same cycle: req is not accepted. The next req is accepted no earlier than the following cycle in IDLE. Back-to-back throughput is therefore at most one degree per d+2 cycles.
- Reset asserted mid-SCAN or in HOLD: immediately (asynchronously) returns to IDLE with deg_valid=0. A pending result is discarded, with no spurious deg_valid after release.

Optional Feature:
- Macro: LT_DEGREE_MAP_FAST_SCAN_EN.
- Defined: SCAN compares THR[idx] and THR[idx+1] each cycle and idx advances by 2. Latency becomes T+ceil(d/2)+1; degree 1 and degree 2 both give T+2. Mapping results are identical to the base behaviour.
- Undefined: one compare per cycle, as in Behaviour.

Decomposition:
- Package lt_pkg holds:
  - RAND_W, NUM_DEG, DEG_W;
  - FSM state enum (IDLE, SCAN, HOLD);
  - threshold constant THR[0..7] = 1638, 9830, 12015, 13107, 13763, 14199, 14512, 16383.
- One sub-module is natural: lt_thr_rom, a combinational index → threshold lookup (two read ports when FAST_SCAN is enabled). The FSM stays in lt_degree_map.

Test Plan:
- rand_in=0, req pulse at T → deg_valid at T+2, degree=1; rand_in=1638 → degree=1; rand_in=1639 → degree=2 at T+3.
- rand_in=16383 → degree=8 at T+9; rand_in=14513 → degree=8; rand_in=14512 → degree=7 at T+8.
- Backpressure: degree=3 result with deg_ready=0 for 5 cycles → deg_valid and degree=3 held stable, busy=1 throughout; second req during hold ignored. After deg_ready=1, busy=0 next cycle.
- Handshake completion and req in the same cycle → no acceptance; a req held high gives acceptance the next cycle and the new result 1+d+1 cycles later.
- rst asserted mid-scan for rand_in=16383 → deg_valid=0, busy=0 immediately; no deg_valid after release until a new req.
- With LT_DEGREE_MAP_FAST_SCAN_EN: rand_in=16383 → degree=8 at T+5; sweep all 16384 samples → degree histogram matches the base build exactly.
